// File: rtl/cmd_frame_pkg.sv
// rtl/cmd_frame_pkg.sv - frame constants and FSM state types shared by the command-frame codec
package cmd_frame_pkg;

    localparam logic [7:0] FRAME_HEAD1 = 8'hAA;
    localparam logic [7:0] FRAME_HEAD2 = 8'h55;
    localparam logic [7:0] FRAME_END   = 8'hEF;

    typedef enum logic [1:0] {
        T_IDLE,
        T_GUARD,
        T_STROBE,
        T_WAIT
    } tx_state_e;

    typedef enum logic [2:0] {
        R_HUNT1,
        R_HUNT2,
        R_CMD,
        R_DATA,
        R_PAR,
        R_END
    } rx_state_e;

endpackage

// File: rtl/cmd_frame_rx.sv
// rtl/cmd_frame_rx.sv - receive parser with header hunt, inter-byte timeout and saturating error count
module cmd_frame_rx
    import cmd_frame_pkg::*;
#(
    parameter int DATA_BYTES = 4,
    parameter int MSB_FIRST  = 1,
    parameter int RX_TIMEOUT = 1000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                byte_rx_data,
    input  logic                      byte_rx_valid,
    input  logic                      byte_rx_err,
    output logic                      cmd_rx_valid,
    output logic [7:0]                cmd_rx_code,
    output logic [8*DATA_BYTES-1:0]   cmd_rx_data,
    output logic                      err_parity,
    output logic                      err_frame,
    output logic                      err_timeout,
    output logic [15:0]               rx_err_count
);
    localparam int W  = 8 * DATA_BYTES;
    localparam int TW = $clog2(RX_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(RX_TIMEOUT - 1);
    localparam logic [4:0]    DCNT_LAST = 5'(DATA_BYTES - 1);

    rx_state_e      state_q, state_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic [4:0]     dcnt_q, dcnt_d;
    logic [7:0]     par_q, par_d;
    logic [7:0]     rpar_q, rpar_d;
    logic [7:0]     code_sh_q, code_sh_d;
    logic [W-1:0]   shadow_q, shadow_d;
    logic           valid_q, valid_d;
    logic [7:0]     code_q, code_d;
    logic [W-1:0]   data_q, data_d;
    logic           perr_q, perr_d;
    logic           ferr_q, ferr_d;
    logic           terr_q, terr_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [4:0]     byte_sel;
    logic [7:0]     pos;

    always_comb begin
        byte_sel = (MSB_FIRST != 0) ? (DCNT_LAST - dcnt_q) : dcnt_q;
        pos      = {byte_sel, 3'b000};

        state_d   = state_q;
        tmo_d     = tmo_q;
        dcnt_d    = dcnt_q;
        par_d     = par_q;
        rpar_d    = rpar_q;
        code_sh_d = code_sh_q;
        shadow_d  = shadow_q;
        valid_d   = 1'b0;
        code_d    = code_q;
        data_d    = data_q;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        terr_d    = 1'b0;

        if (byte_rx_valid) begin
            tmo_d = '0;
            if (byte_rx_err) begin
                // A corrupted byte while hunting is just line noise, not a broken frame.
                if (state_q != R_HUNT1) begin
                    ferr_d  = 1'b1;
                    state_d = R_HUNT1;
                end
            end else begin
                case (state_q)
                    R_HUNT1: if (byte_rx_data == FRAME_HEAD1) state_d = R_HUNT2;
                    R_HUNT2: begin
                        if (byte_rx_data == FRAME_HEAD2)      state_d = R_CMD;
                        else if (byte_rx_data != FRAME_HEAD1) state_d = R_HUNT1;
                    end
                    R_CMD: begin
                        code_sh_d = byte_rx_data;
                        par_d     = byte_rx_data;
                        dcnt_d    = '0;
                        state_d   = R_DATA;
                    end
                    R_DATA: begin
                        shadow_d = (shadow_q & ~(W'(8'hFF) << pos)) | (W'(byte_rx_data) << pos);
                        par_d    = par_q ^ byte_rx_data;
                        dcnt_d   = dcnt_q + 5'd1;
                        if (dcnt_q == DCNT_LAST) state_d = R_PAR;
                    end
                    R_PAR: begin
                        rpar_d  = byte_rx_data;
                        state_d = R_END;
                    end
                    R_END: begin
                        state_d = R_HUNT1;
                        if (par_q != rpar_q) begin
                            perr_d = 1'b1;
                        end else if (byte_rx_data != FRAME_END) begin
                            ferr_d = 1'b1;
                        end else begin
                            valid_d = 1'b1;
                            code_d  = code_sh_q;
                            data_d  = shadow_q;
                        end
                    end
                    default: state_d = R_HUNT1;
                endcase
            end
        end else if (state_q != R_HUNT1) begin
            if (tmo_q == TMO_LAST) begin
                terr_d  = 1'b1;
                tmo_d   = '0;
                state_d = R_HUNT1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end else begin
            tmo_d = '0;
        end

        cnt_d = cnt_q;
        if ((perr_d || ferr_d || terr_d) && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= R_HUNT1;
            tmo_q     <= '0;
            dcnt_q    <= '0;
            par_q     <= '0;
            rpar_q    <= '0;
            code_sh_q <= '0;
            shadow_q  <= '0;
            valid_q   <= 1'b0;
            code_q    <= '0;
            data_q    <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            terr_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            dcnt_q    <= dcnt_d;
            par_q     <= par_d;
            rpar_q    <= rpar_d;
            code_sh_q <= code_sh_d;
            shadow_q  <= shadow_d;
            valid_q   <= valid_d;
            code_q    <= code_d;
            data_q    <= data_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            terr_q    <= terr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign cmd_rx_valid = valid_q;
    assign cmd_rx_code  = code_q;
    assign cmd_rx_data  = data_q;
    assign err_parity   = perr_q;
    assign err_frame    = ferr_q;
    assign err_timeout  = terr_q;
    assign rx_err_count = cnt_q;

endmodule

// File: rtl/cmd_frame_codec.sv
// rtl/cmd_frame_codec.sv - command-frame encoder (guarded byte transmit FSM) plus receive parser instance
module cmd_frame_codec
    import cmd_frame_pkg::*;
#(
    parameter int DATA_BYTES   = 4,
    parameter int MSB_FIRST    = 1,
    parameter int RX_TIMEOUT   = 1000,
    parameter int GUARD_CYCLES = 100
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_tx_valid,
    output logic                      cmd_tx_ready,
    input  logic [7:0]                cmd_tx_code,
    input  logic [8*DATA_BYTES-1:0]   cmd_tx_data,
    output logic                      cmd_tx_done,
    output logic                      tx_busy,
    output logic [7:0]                byte_tx_data,
    output logic                      byte_tx_valid,
    input  logic                      byte_tx_busy,
    input  logic                      byte_tx_over,
    input  logic [7:0]                byte_rx_data,
    input  logic                      byte_rx_valid,
    input  logic                      byte_rx_err,
    output logic                      cmd_rx_valid,
    output logic [7:0]                cmd_rx_code,
    output logic [8*DATA_BYTES-1:0]   cmd_rx_data,
    output logic                      err_parity,
    output logic                      err_frame,
    output logic                      err_timeout,
    output logic [15:0]               rx_err_count
);
    localparam int W  = 8 * DATA_BYTES;
    localparam int GW = $clog2(GUARD_CYCLES + 1);
    localparam logic [GW-1:0] GUARD_MAX = GW'(GUARD_CYCLES);
    localparam logic [4:0]    PAR_IDX   = 5'(DATA_BYTES + 3);
    localparam logic [4:0]    END_IDX   = 5'(DATA_BYTES + 4);

    tx_state_e      state_q, state_d;
    logic [7:0]     code_q, code_d;
    logic [W-1:0]   data_q, data_d;
    logic [4:0]     idx_q, idx_d;
    logic [7:0]     par_q, par_d;
    logic [GW-1:0]  guard_q, guard_d;
    logic           done_q, done_d;
    logic [4:0]     data_idx;
    logic [4:0]     byte_sel;
    logic [7:0]     data_byte;
    logic [7:0]     cur_byte;

    // Wire byte at the current index: header, code, payload, running parity, end marker.
    always_comb begin
        data_idx  = idx_q - 5'd3;
        byte_sel  = (MSB_FIRST != 0) ? (5'(DATA_BYTES - 1) - data_idx) : data_idx;
        data_byte = 8'(data_q >> {byte_sel, 3'b000});
        if (idx_q == 5'd0)         cur_byte = FRAME_HEAD1;
        else if (idx_q == 5'd1)    cur_byte = FRAME_HEAD2;
        else if (idx_q == 5'd2)    cur_byte = code_q;
        else if (idx_q == PAR_IDX) cur_byte = par_q;
        else if (idx_q == END_IDX) cur_byte = FRAME_END;
        else                       cur_byte = data_byte;
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        data_d  = data_q;
        idx_d   = idx_q;
        par_d   = par_q;
        done_d  = 1'b0;

        if (byte_tx_busy)            guard_d = '0;
        else if (guard_q == GUARD_MAX) guard_d = guard_q;
        else                         guard_d = guard_q + 1'b1;

        case (state_q)
            T_IDLE: begin
                if (cmd_tx_valid) begin
                    code_d  = cmd_tx_code;
                    data_d  = cmd_tx_data;
                    idx_d   = '0;
                    par_d   = cmd_tx_code;
                    state_d = T_GUARD;
                end
            end
            T_GUARD:  if (guard_q == GUARD_MAX && !byte_tx_busy) state_d = T_STROBE;
            T_STROBE: state_d = T_WAIT;
            T_WAIT: begin
                if (byte_tx_over) begin
                    idx_d = idx_q + 5'd1;
                    if (idx_q >= 5'd3 && idx_q < PAR_IDX) par_d = par_q ^ cur_byte;
                    if (idx_q == END_IDX) begin
                        done_d  = 1'b1;
                        state_d = T_IDLE;
                    end else begin
                        state_d = T_GUARD;
                    end
                end
            end
            default: state_d = T_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= T_IDLE;
            code_q  <= '0;
            data_q  <= '0;
            idx_q   <= '0;
            par_q   <= '0;
            guard_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            par_q   <= par_d;
            guard_q <= guard_d;
            done_q  <= done_d;
        end
    end

    // done is registered so it coincides with the first idle (ready) cycle.
    assign cmd_tx_ready  = (state_q == T_IDLE);
    assign tx_busy       = (state_q != T_IDLE);
    assign cmd_tx_done   = done_q;
    assign byte_tx_valid = (state_q == T_STROBE);
    assign byte_tx_data  = byte_tx_valid ? cur_byte : 8'h00;

    cmd_frame_rx #(
        .DATA_BYTES (DATA_BYTES),
        .MSB_FIRST  (MSB_FIRST),
        .RX_TIMEOUT (RX_TIMEOUT)
    ) u_rx (
        .clk           (clk),
        .rst           (rst),
        .byte_rx_data  (byte_rx_data),
        .byte_rx_valid (byte_rx_valid),
        .byte_rx_err   (byte_rx_err),
        .cmd_rx_valid  (cmd_rx_valid),
        .cmd_rx_code   (cmd_rx_code),
        .cmd_rx_data   (cmd_rx_data),
        .err_parity    (err_parity),
        .err_frame     (err_frame),
        .err_timeout   (err_timeout),
        .rx_err_count  (rx_err_count)
    );

endmodule

// File: doc/cmd_frame_codec.md
Name: cmd_frame_codec

Overview:
Parametrised command-frame encoder/decoder between host logic and a byte-level UART transceiver. Frame format: AA 55 CMD D[0..DATA_BYTES-1] PARITY EF. The payload width and byte order are set by parameters; the byte order is not a compile-time define. Adds resynchronising header hunt, typed error pulses, a saturating error counter and a valid/ready command-transmit handshake. Instantiated once per serial link, next to that link's uart_transceiver.

Parameters:
DATA_BYTES, 4, payload length in bytes; legal range 1..16; payload width W = 8*DATA_BYTES.
MSB_FIRST, 1, 1 = most significant payload byte on the wire first; 0 = least significant first.
RX_TIMEOUT, 1000, maximum clk cycles allowed between consecutive rx bytes inside a frame.
GUARD_CYCLES, 100, idle clk cycles required on the transmitter before each tx byte strobe.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cmd_tx_valid  in  1  transmit request
cmd_tx_ready  out  1  high when a new request can be accepted
cmd_tx_code  in  8  command byte to send
cmd_tx_data  in  W  payload to send
cmd_tx_done  out  1  one-cycle pulse when the EF byte has completed
tx_busy  out  1  high from request acceptance until cmd_tx_done
byte_tx_data  out  8  byte to the UART
byte_tx_valid  out  1  one-cycle strobe to the UART
byte_tx_busy  in  1  UART is shifting a byte out
byte_tx_over  in  1  UART byte-complete pulse
byte_rx_data  in  8  received byte
byte_rx_valid  in  1  received-byte pulse
byte_rx_err  in  1  framing error on the current byte; qualified by byte_rx_valid
cmd_rx_valid  out  1  one-cycle pulse: a good frame was decoded
cmd_rx_code  out  8  decoded command byte; held until the next good frame
cmd_rx_data  out  W  decoded payload; held until the next good frame
err_parity  out  1  pulse: parity byte mismatch
err_frame  out  1  pulse: end byte is not EF, or byte_rx_err occurred mid-frame
err_timeout  out  1  pulse: inter-byte timeout expired
rx_err_count  out  16  saturating count of all error pulses

Behaviour:
Reset (all outputs): every output is 0, except cmd_tx_ready, which is 1. Both FSMs return to idle. A reset mid-frame abandons the frame and drops byte_tx_valid immediately; no done or error pulse is generated.

Parity: XOR of CMD and all payload bytes. It is accumulated per byte, not computed as one wide XOR.

Byte order: byte index i=0..DATA_BYTES-1 in wire order. If MSB_FIRST=1, byte i maps to data[W-1-8i -: 8]. If MSB_FIRST=0, byte i maps to data[8i +: 8].

TX FSM (T_IDLE, T_GUARD, T_STROBE, T_WAIT):
- cmd_tx_ready = (state == T_IDLE). On cmd_tx_valid && cmd_tx_ready: latch code and data, clear the byte index, raise tx_busy, go to T_GUARD.
- Guard counter: clears while byte_tx_busy=1, otherwise increments and saturates at GUARD_CYCLES.
- T_GUARD: when the counter equals GUARD_CYCLES and byte_tx_busy=0, go to T_STROBE.
- T_STROBE: byte_tx_valid=1 for exactly one cycle, with byte_tx_data = byte[index]. Go to T_WAIT.
- T_WAIT: on byte_tx_over, increment the index. If the last byte (index DATA_BYTES+4) has completed, pulse cmd_tx_done, drop tx_busy and go to T_IDLE. Otherwise go to T_GUARD.
- cmd_tx_ready returns to 1 in the same cycle as cmd_tx_done. A back-to-back request is then accepted on the following edge.

RX FSM (R_HUNT1, R_HUNT2, R_CMD, R_DATA, R_PAR, R_END):
- R_HUNT1: on byte AA go to R_HUNT2; any other byte is dropped silently.
- R_HUNT2: byte 55 goes to R_CMD; byte AA stays in R_HUNT2 (resync); any other byte goes to R_HUNT1.
- R_CMD stores the code and seeds parity. R_DATA stores DATA_BYTES bytes into a shadow register. R_PAR stores the parity byte. R_END checks the end byte.
- On the END byte: if parity matches and the byte is EF, then on the next cycle copy the shadow into cmd_rx_code/cmd_rx_data and pulse cmd_rx_valid. Latency is 1 clk after the END byte's byte_rx_valid.
- On a parity mismatch: err_parity only, even if the end byte is also wrong. On a wrong end byte alone: err_frame.
- byte_rx_valid && byte_rx_err in any state other than R_HUNT1: err_frame, go to R_HUNT1. The same in R_HUNT1: byte ignored, no error.
- Timeout counter: clears on every byte_rx_valid and increments in states other than R_HUNT1. At RX_TIMEOUT: err_timeout, go to R_HUNT1. If a byte arrives in the cycle the count reaches RX_TIMEOUT, the byte wins.
- rx_err_count increments by 1 on each cycle with any error pulse and saturates at FFFF.
- TX and RX are fully independent; simultaneous activity on both is legal.

Decomposition:
- Package cmd_frame_pkg: FRAME_HEAD1=8'hAA, FRAME_HEAD2=8'h55, FRAME_END=8'hEF, and the TX and RX state enumerations.
- Sub-module cmd_frame_rx holds the receive parser, timeout counter and error counter. The top-level module holds the TX FSM and instantiates cmd_frame_rx.

Test Plan:
1. DATA_BYTES=4, MSB_FIRST=1. Send code 12, data DEADBEEF. Wire bytes: AA 55 12 DE AD BE EF 30 EF. Each strobe follows ≥100 idle cycles. cmd_tx_done pulses once.
2. Loop the bytes from test 1 into rx. cmd_rx_valid pulses 1 clk after the last byte, with code=12 and data=DEADBEEF. No error pulses.
3. RX the same frame with parity 31. err_parity pulses, rx_err_count=1, no cmd_rx_valid, and the previous outputs are held.
4. RX AA AA 55 12 DE AD BE EF 30 EF. The frame is accepted (resync path).
5. RX AA 55 12, then idle. err_timeout pulses exactly 1000 cycles after byte 12, and the FSM is back in hunt.
6. DATA_BYTES=2, MSB_FIRST=0. RX AA 55 07 34 12 21 EF gives data=1234. Assert rst mid-frame: all outputs clear and the next full frame decodes.
